// File: rtl/cycle_sensor_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : cycle_sensor_counter_if
// Description : Bundle of raw sensor inputs and the six count buses that the
//               cycle_sensor_counter block hands to the ahb_switches slave.
//               master : the counter block (takes raw inputs, drives counts)
//               slave  : the consumer side (drives raw inputs, reads counts)
// Signals     : Fork, Crank, Mode, Trip                 raw async inputs
//               Switch_count_of_total_time   [31:0]     ticks since reset
//               Switch_count_of_fork         [15:0]     fork rising edges
//               Switch_count_of_time_per_cycle_of_crank [15:0] crank period
//               Switch_count_of_time_per_cycle_of_fork  [15:0] fork period
//               Switch_count_of_mode         [15:0]     mode presses
//               Switch_count_of_trip         [15:0]     trip presses
// Revision    : 1.0  initial release
// ============================================================================
interface cycle_sensor_counter_if;
    logic        Fork;
    logic        Crank;
    logic        Mode;
    logic        Trip;
    logic [31:0] Switch_count_of_total_time;
    logic [15:0] Switch_count_of_fork;
    logic [15:0] Switch_count_of_time_per_cycle_of_crank;
    logic [15:0] Switch_count_of_time_per_cycle_of_fork;
    logic [15:0] Switch_count_of_mode;
    logic [15:0] Switch_count_of_trip;

    modport master (
        input  Fork, Crank, Mode, Trip,
        output Switch_count_of_total_time, Switch_count_of_fork,
               Switch_count_of_time_per_cycle_of_crank,
               Switch_count_of_time_per_cycle_of_fork,
               Switch_count_of_mode, Switch_count_of_trip
    );

    modport slave (
        output Fork, Crank, Mode, Trip,
        input  Switch_count_of_total_time, Switch_count_of_fork,
               Switch_count_of_time_per_cycle_of_crank,
               Switch_count_of_time_per_cycle_of_fork,
               Switch_count_of_mode, Switch_count_of_trip
    );
endinterface
`default_nettype wire

// File: rtl/cycle_sensor_counter.sv
`default_nettype none
// ============================================================================
// Module      : cycle_sensor_counter
// Description : Synchronises and debounces the fork, crank, mode and trip
//               switches, derives a prescaled tick, and maintains event
//               counts, elapsed ticks and per-revolution periods for the
//               fork and crank sensors. All outputs are registered.
// Ports       : HCLK    system clock
//               HRESET  synchronous active-high reset
//               bus     cycle_sensor_counter_if.master (raw inputs in,
//                       six count buses out)
// Parameters  : TICK_DIV        HCLK cycles per tick (>= 2)
//               DEBOUNCE_TICKS  ticks of disagreement before a state change
//               STOP_TICKS      idle ticks before a period reads 0 (<= 65535)
// Options     : TRIP_CLEAR_EN   when defined, a trip press also clears total
//                               time, fork count and both period channels
// Revision    : 1.0  initial release
// ============================================================================
module cycle_sensor_counter #(
    parameter int TICK_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 5,
    parameter int STOP_TICKS     = 3000
) (
    input  wire logic               HCLK,
    input  wire logic               HRESET,
    cycle_sensor_counter_if.master  bus
);

    // Bit positions of the four channels in the packed input vectors.
    localparam int c_FORK  = 0;
    localparam int c_CRANK = 1;
    localparam int c_MODE  = 2;
    localparam int c_TRIP  = 3;

    localparam int          c_PW   = $clog2(TICK_DIV);
    localparam int          c_DW   = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [15:0] c_STOP = 16'(STOP_TICKS);

    logic [3:0]      w_raw;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [c_PW-1:0] r_presc;
    logic            w_tick;
    logic [3:0]      w_db;
    logic [3:0]      r_db_d;
    logic [3:0]      w_pulse;
    logic            w_clr;
    logic [15:0]     w_period [2];

    logic [31:0]     r_total;
    logic [15:0]     r_cnt_fork;
    logic [15:0]     r_cnt_mode;
    logic [15:0]     r_cnt_trip;

    assign w_raw = {bus.Trip, bus.Mode, bus.Crank, bus.Fork};

    // Two-flop synchroniser for every raw input.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Prescaler: tick is high for the single cycle at the top of the count.
    assign w_tick = (r_presc == c_PW'(TICK_DIV - 1));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    // Debounce: the state follows the synced level only after it has
    // disagreed on DEBOUNCE_TICKS consecutive ticks.
    for (genvar i = 0; i < 4; i++) begin : g_db
        logic            r_state;
        logic [c_DW-1:0] r_cnt;

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                r_state <= 1'b0;
                r_cnt   <= '0;
            end else if (w_tick) begin
                if (r_sync2[i] != r_state) begin
                    // The tick that would bring the count to the limit flips
                    // the state instead of storing the limit.
                    if (r_cnt == c_DW'(DEBOUNCE_TICKS - 1)) begin
                        r_state <= r_sync2[i];
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + c_DW'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_db[i] = r_state;
    end

    // Rising-edge pulse, high in the cycle right after the debounced state
    // goes 0 -> 1. Built from registers only.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_db_d <= '0;
        end else begin
            r_db_d <= w_db;
        end
    end

    assign w_pulse = w_db & ~r_db_d;

`ifdef TRIP_CLEAR_EN
    assign w_clr = w_pulse[c_TRIP];
`else
    assign w_clr = 1'b0;
`endif

    // Period measurement for fork (0) and crank (1). The first edge after
    // reset or after a stop only arms; the next one publishes a period.
    for (genvar k = 0; k < 2; k++) begin : g_period
        logic [15:0] r_interval;
        logic [15:0] r_period;
        logic        r_armed;

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                r_interval <= '0;
                r_period   <= '0;
                r_armed    <= 1'b0;
            end else if (w_clr) begin
                // A coincident edge still arms so the next edge is measured.
                r_interval <= '0;
                r_period   <= '0;
                r_armed    <= w_pulse[k];
            end else if (w_pulse[k]) begin
                // Edge beats a coincident tick: that tick is not counted.
                r_interval <= '0;
                if (r_armed) begin
                    r_period <= r_interval;
                end else begin
                    r_armed  <= 1'b1;
                end
            end else if (r_interval == c_STOP) begin
                r_period <= '0;
                r_armed  <= 1'b0;
            end else if (w_tick) begin
                r_interval <= r_interval + 16'd1;
            end
        end

        assign w_period[k] = r_period;
    end

    // Event and elapsed-time counters; all wrap naturally.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_total    <= '0;
            r_cnt_fork <= '0;
            r_cnt_mode <= '0;
            r_cnt_trip <= '0;
        end else begin
            if (w_clr) begin
                r_total <= '0;
            end else if (w_tick) begin
                r_total <= r_total + 32'd1;
            end

            if (w_clr) begin
                r_cnt_fork <= '0;
            end else if (w_pulse[c_FORK]) begin
                r_cnt_fork <= r_cnt_fork + 16'd1;
            end

            if (w_pulse[c_MODE]) begin
                r_cnt_mode <= r_cnt_mode + 16'd1;
            end

            if (w_pulse[c_TRIP]) begin
                r_cnt_trip <= r_cnt_trip + 16'd1;
            end
        end
    end

    assign bus.Switch_count_of_total_time              = r_total;
    assign bus.Switch_count_of_fork                    = r_cnt_fork;
    assign bus.Switch_count_of_time_per_cycle_of_fork  = w_period[c_FORK];
    assign bus.Switch_count_of_time_per_cycle_of_crank = w_period[c_CRANK];
    assign bus.Switch_count_of_mode                    = r_cnt_mode;
    assign bus.Switch_count_of_trip                    = r_cnt_trip;

endmodule
`default_nettype wire

// File: tb/tb_cycle_sensor_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cycle_sensor_counter
// Description : Directed self-checking bench for cycle_sensor_counter with
//               TICK_DIV=4, DEBOUNCE_TICKS=2, STOP_TICKS=50. Inputs change
//               1 time unit after a rising edge; outputs are sampled there.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cycle_sensor_counter;

    logic        HCLK   = 1'b0;
    logic        HRESET = 1'b1;
    int unsigned n_chk  = 0;
    int unsigned n_bad  = 0;
    int unsigned n_cyc  = 0;   // rising edges since reset released

    cycle_sensor_counter_if u_bus ();

    cycle_sensor_counter #(
        .TICK_DIV       (4),
        .DEBOUNCE_TICKS (2),
        .STOP_TICKS     (50)
    ) u_dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (u_bus)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) begin
        if (HRESET) n_cyc <= 0;
        else        n_cyc <= n_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_total"}, u_bus.Switch_count_of_total_time, 32'd0);
        chk({tag, "_fork"},  32'(u_bus.Switch_count_of_fork), 32'd0);
        chk({tag, "_fper"},  32'(u_bus.Switch_count_of_time_per_cycle_of_fork), 32'd0);
        chk({tag, "_cper"},  32'(u_bus.Switch_count_of_time_per_cycle_of_crank), 32'd0);
        chk({tag, "_mode"},  32'(u_bus.Switch_count_of_mode), 32'd0);
        chk({tag, "_trip"},  32'(u_bus.Switch_count_of_trip), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        u_bus.Fork  = 1'b0;
        u_bus.Crank = 1'b0;
        u_bus.Mode  = 1'b0;
        u_bus.Trip  = 1'b0;

        // Reset state
        step(3);
        chk_all_zero("reset");
        HRESET = 1'b0;

        // 400 idle cycles = 100 ticks
        step(400);
        chk("idle_total", u_bus.Switch_count_of_total_time, 32'd100);
        chk("idle_fork",  32'(u_bus.Switch_count_of_fork), 32'd0);
        chk("idle_fper",  32'(u_bus.Switch_count_of_time_per_cycle_of_fork), 32'd0);

        // 3-cycle bounce is shorter than one tick: rejected
        u_bus.Fork = 1'b1;
        step(3);
        u_bus.Fork = 1'b0;
        step(40);
        chk("bounce_fork", 32'(u_bus.Switch_count_of_fork), 32'd0);

        // Three clean fork pulses every 40 cycles: period 40/4 = 10 ticks
        for (int p = 1; p <= 3; p++) begin
            u_bus.Fork = 1'b1;
            step(20);
            u_bus.Fork = 1'b0;
            step(20);
            chk($sformatf("pulse%0d_fork", p), 32'(u_bus.Switch_count_of_fork), 32'(p));
            chk($sformatf("pulse%0d_fper", p),
                32'(u_bus.Switch_count_of_time_per_cycle_of_fork), (p == 1) ? 32'd0 : 32'd10);
        end

        // 220 idle cycles (> 50 ticks): stopped
        step(220);
        chk("stop_fper", 32'(u_bus.Switch_count_of_time_per_cycle_of_fork), 32'd0);

        // A single edge after a stop only re-arms
        u_bus.Fork = 1'b1;
        step(20);
        u_bus.Fork = 1'b0;
        step(20);
        chk("rearm_fork", 32'(u_bus.Switch_count_of_fork), 32'd4);
        chk("rearm_fper", 32'(u_bus.Switch_count_of_time_per_cycle_of_fork), 32'd0);

        // Fork every 40 cycles, crank every 60 cycles, independently
        for (int c = 0; c < 240; c++) begin
            u_bus.Fork  = ((c % 40) < 20);
            u_bus.Crank = ((c % 60) < 30);
            step(1);
        end
        chk("mix_fork",  32'(u_bus.Switch_count_of_fork), 32'd10);
        chk("mix_fper",  32'(u_bus.Switch_count_of_time_per_cycle_of_fork), 32'd10);
        chk("mix_cper",  32'(u_bus.Switch_count_of_time_per_cycle_of_crank), 32'd15);
        chk("mix_total", u_bus.Switch_count_of_total_time, n_cyc / 4);

        // Two mode presses
        for (int m = 0; m < 2; m++) begin
            u_bus.Mode = 1'b1;
            step(20);
            u_bus.Mode = 1'b0;
            step(20);
        end
        chk("mode_cnt", 32'(u_bus.Switch_count_of_mode), 32'd2);
        chk("mode_trip", 32'(u_bus.Switch_count_of_trip), 32'd0);

        // One trip press; inspect the cycle the trip count first moves
        u_bus.Trip = 1'b1;
        for (int i = 0; i < 60 && u_bus.Switch_count_of_trip == 16'd0; i++) begin
            step(1);
        end
        chk("trip_cnt", 32'(u_bus.Switch_count_of_trip), 32'd1);
`ifdef TRIP_CLEAR_EN
        chk("trip_total", u_bus.Switch_count_of_total_time, 32'd0);
        chk("trip_fork",  32'(u_bus.Switch_count_of_fork), 32'd0);
        chk("trip_fper",  32'(u_bus.Switch_count_of_time_per_cycle_of_fork), 32'd0);
        chk("trip_cper",  32'(u_bus.Switch_count_of_time_per_cycle_of_crank), 32'd0);
`else
        chk("trip_total", u_bus.Switch_count_of_total_time, n_cyc / 4);
        chk("trip_fork",  32'(u_bus.Switch_count_of_fork), 32'd10);
        chk("trip_fper",  32'(u_bus.Switch_count_of_time_per_cycle_of_fork), 32'd10);
        chk("trip_cper",  32'(u_bus.Switch_count_of_time_per_cycle_of_crank), 32'd15);
`endif
        step(20);
        u_bus.Trip = 1'b0;
        step(20);
        chk("trip_release", 32'(u_bus.Switch_count_of_trip), 32'd1);
        chk("mode_hold",    32'(u_bus.Switch_count_of_mode), 32'd2);

        // Reset mid-run with a partial fork debounce in flight
        u_bus.Fork = 1'b1;
        step(5);
        HRESET = 1'b1;
        step(1);
        chk_all_zero("midreset");
        HRESET = 1'b0;
        step(8);
        chk("post_reset_total", u_bus.Switch_count_of_total_time, 32'd2);
        // Fork still high: debounce restarts from 0, so one fresh edge counts
        step(40);
        chk("post_reset_fork", 32'(u_bus.Switch_count_of_fork), 32'd1);
        chk("post_reset_fper", 32'(u_bus.Switch_count_of_time_per_cycle_of_fork), 32'd0);
        u_bus.Fork = 1'b0;
        step(10);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
